// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer prefetch path:
// frame geometry, address width, buffer bases and FSM states.
package fb_pkg;

   localparam int IMG_WIDTH        = 320;
   localparam int IMG_HEIGHT       = 240;
   localparam int PIXELS_PER_FRAME = IMG_WIDTH * IMG_HEIGHT;
   localparam int ADDR_W           = 18;
   localparam int BUF0_BASE        = 0;
   localparam int BUF1_BASE        = 76800;
   localparam int PIX_W            = 16;
   localparam int LATE_W           = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_FILL  = 2'd2,
      ST_DRAIN = 2'd3
   } fb_state_t;

endpackage

// File: rtl/fb_read_pipe.sv
// Two-stage read-return pipeline: stage 1 tracks the RAM latency,
// stage 2 registers RAM data as a FIFO push.
// Ports:
//   clk_vga, rst      : pixel clock, async active-high reset
//   i_kill            : synchronous squash of both valid bits
//   i_rd_en/i_rd_last : read issued this cycle / it is the frame's last
//   i_rd_data         : RAM data, valid one cycle after i_rd_en
//   o_we/o_data       : FIFO push strobe and pixel
//   o_done            : coincides with the push of the last pixel
//   o_last_pend       : last pixel sits in stage 1 (pushes next cycle)
module fb_read_pipe
   import fb_pkg::*;
#(
   parameter int DATA_W = PIX_W
) (
   input  logic              clk_vga,
   input  logic              rst,
   input  logic              i_kill,
   input  logic              i_rd_en,
   input  logic              i_rd_last,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic              o_we,
   output logic [DATA_W-1:0] o_data,
   output logic              o_done,
   output logic              o_last_pend
);

   logic              r_v1;
   logic              r_last1;
   logic              r_we;
   logic              r_done;
   logic [DATA_W-1:0] r_data;

   always_ff @(posedge clk_vga or posedge rst) begin
      if (rst) begin
         r_v1    <= 1'b0;
         r_last1 <= 1'b0;
         r_we    <= 1'b0;
         r_done  <= 1'b0;
         r_data  <= '0;
      end else begin
         // A kill drops both the read in the RAM and the word
         // about to be pushed, so no stale pixel reaches the FIFO.
         r_v1    <= i_rd_en & ~i_kill;
         r_last1 <= i_rd_en & i_rd_last & ~i_kill;
         r_we    <= r_v1 & ~i_kill;
         r_done  <= r_v1 & r_last1 & ~i_kill;
         if (r_v1) begin
            r_data <= i_rd_data;
         end
      end
   end

   assign o_we        = r_we;
   assign o_data      = r_data;
   assign o_done      = r_done;
   assign o_last_pend = r_v1 & r_last1;

endmodule

// File: rtl/frame_buffer_prefetcher.sv
// Streams one frame from a framebuffer RAM into the VGA pixel FIFO,
// restarted by frame_sync, throttled on the FIFO half-full flag.
// Ports:
//   clk_vga, rst               : pixel clock, async active-high reset
//   frame_sync, buf_sel        : start pulse, buffer select at start
//   mem_rd_en, mem_addr        : registered RAM read strobe/address
//   mem_rd_data                : RAM data, one cycle after the strobe
//   fifo_flush                 : one-cycle FIFO clear
//   fifo_write_enable/_data    : registered FIFO push
//   fifo_full, fifo_half_full  : FIFO flags
//   frame_done                 : pulse with the last push of a frame
//   busy                       : FSM outside IDLE
//   late_frames                : saturating count of late frame_sync
module frame_buffer_prefetcher #(
   parameter int IMG_WIDTH  = fb_pkg::IMG_WIDTH,
   parameter int IMG_HEIGHT = fb_pkg::IMG_HEIGHT,
   parameter int ADDR_W     = fb_pkg::ADDR_W,
   parameter int BUF0_BASE  = fb_pkg::BUF0_BASE,
   parameter int BUF1_BASE  = fb_pkg::BUF1_BASE
) (
   input  logic              clk_vga,
   input  logic              rst,
   input  logic              frame_sync,
   input  logic              buf_sel,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [15:0]       mem_rd_data,
   output logic              fifo_flush,
   output logic              fifo_write_enable,
   output logic [15:0]       fifo_write_data,
   input  logic              fifo_full,
   input  logic              fifo_half_full,
   output logic              frame_done,
   output logic              busy,
   output logic [7:0]        late_frames
);

   import fb_pkg::*;

   localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
   localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NPIX - 1);
   localparam logic [ADDR_W-1:0] BASE0    = ADDR_W'(BUF0_BASE);
   localparam logic [ADDR_W-1:0] BASE1    = ADDR_W'(BUF1_BASE);

   fb_state_t         r_state;
   fb_state_t         w_state_nxt;
   logic              r_flush_ph;
   logic              w_flush_ph_nxt;
   logic [ADDR_W-1:0] r_base;
   logic [IDX_W-1:0]  r_idx;
   logic              r_rd_en;
   logic              r_rd_last;
   logic [ADDR_W-1:0] r_addr;
   logic              r_flush;
   logic [7:0]        r_late;

   logic w_can_rd;
   logic w_issue;
   logic w_is_last;
   logic w_flush_set;
   logic w_late_inc;
   logic w_last_pend;
   logic w_push;
   logic w_done;
   logic [15:0] w_push_data;

   assign w_can_rd   = ~fifo_half_full & ~fifo_full;
   assign w_is_last  = (r_idx == LAST_IDX);
   assign w_late_inc = frame_sync & (r_state != ST_IDLE)
                     & (r_late != 8'hFF);

   // The read strobe is registered, so the issue decision is made one
   // cycle early: the second FLUSH cycle decides the first read, which
   // also gives the flags a cycle to settle after the flush.
   always_comb begin
      w_state_nxt    = r_state;
      w_flush_ph_nxt = 1'b0;
      w_issue        = 1'b0;
      w_flush_set    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_state_nxt = ST_IDLE;
         end
         ST_FLUSH: begin
            w_flush_ph_nxt = ~r_flush_ph;
            if (r_flush_ph) begin
               w_state_nxt = ST_FILL;
               w_issue     = w_can_rd;
            end
         end
         ST_FILL: begin
            w_issue = w_can_rd;
         end
         ST_DRAIN: begin
            if (w_last_pend) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      if (w_issue && w_is_last) begin
         w_state_nxt = ST_DRAIN;
      end
      // A new frame always wins, even over the final push.
      if (frame_sync) begin
         w_state_nxt    = ST_FLUSH;
         w_flush_ph_nxt = 1'b0;
         w_issue        = 1'b0;
         w_flush_set    = 1'b1;
      end
   end

   always_ff @(posedge clk_vga or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_flush_ph <= 1'b0;
         r_base     <= BASE0;
         r_idx      <= '0;
         r_rd_en    <= 1'b0;
         r_rd_last  <= 1'b0;
         r_addr     <= '0;
         r_flush    <= 1'b0;
         r_late     <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_flush_ph <= w_flush_ph_nxt;
         r_flush    <= w_flush_set;
         r_rd_en    <= w_issue;
         r_rd_last  <= w_issue & w_is_last;
         if (w_issue) begin
            r_addr <= r_base + ADDR_W'(r_idx);
            r_idx  <= r_idx + IDX_W'(1);
         end
         if (frame_sync) begin
            r_base <= buf_sel ? BASE1 : BASE0;
            r_idx  <= '0;
         end
         if (w_late_inc) begin
            r_late <= r_late + 8'd1;
         end
      end
   end

   fb_read_pipe #(
      .DATA_W (16)
   ) u_pipe (
      .clk_vga     (clk_vga),
      .rst         (rst),
      .i_kill      (frame_sync),
      .i_rd_en     (r_rd_en),
      .i_rd_last   (r_rd_last),
      .i_rd_data   (mem_rd_data),
      .o_we        (w_push),
      .o_data      (w_push_data),
      .o_done      (w_done),
      .o_last_pend (w_last_pend)
   );

   assign mem_rd_en         = r_rd_en;
   assign mem_addr          = r_addr;
   assign fifo_flush        = r_flush;
   assign fifo_write_enable = w_push;
   assign fifo_write_data   = w_push_data;
   assign frame_done        = w_done;
   assign busy              = (r_state != ST_IDLE);
   assign late_frames       = r_late;

endmodule

// File: tb/tb_frame_buffer_prefetcher.sv
// Self-checking bench for frame_buffer_prefetcher on a 16x4 frame,
// with a registered RAM model and a configurable FIFO model.
module tb_frame_buffer_prefetcher;

   localparam int W  = 16;
   localparam int H  = 4;
   localparam int N  = W * H;
   localparam int AW = 18;
   localparam int B0 = 0;
   localparam int B1 = 76800;

   logic          clk_vga = 1'b0;
   logic          rst = 1'b0;
   logic          frame_sync = 1'b0;
   logic          buf_sel = 1'b0;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_rd_data;
   logic          fifo_flush;
   logic          fifo_write_enable;
   logic [15:0]   fifo_write_data;
   logic          fifo_full;
   logic          fifo_half_full;
   logic          frame_done;
   logic          busy;
   logic [7:0]    late_frames;

   frame_buffer_prefetcher #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .ADDR_W     (AW),
      .BUF0_BASE  (B0),
      .BUF1_BASE  (B1)
   ) dut (
      .clk_vga           (clk_vga),
      .rst               (rst),
      .frame_sync        (frame_sync),
      .buf_sel           (buf_sel),
      .mem_rd_en         (mem_rd_en),
      .mem_addr          (mem_addr),
      .mem_rd_data       (mem_rd_data),
      .fifo_flush        (fifo_flush),
      .fifo_write_enable (fifo_write_enable),
      .fifo_write_data   (fifo_write_data),
      .fifo_full         (fifo_full),
      .fifo_half_full    (fifo_half_full),
      .frame_done        (frame_done),
      .busy              (busy),
      .late_frames       (late_frames)
   );

   always #20 clk_vga = ~clk_vga;

   int cyc = 0;
   always @(posedge clk_vga) cyc <= cyc + 1;

   // RAM returns addr[15:0] one cycle after the strobe
   logic [15:0] ram_q = 16'h0;
   always @(posedge clk_vga) begin
      if (mem_rd_en) ram_q <= mem_addr[15:0];
   end
   assign mem_rd_data = ram_q;

   // mode 0: always empty; mode 1: depth 8, one pop every 2 cycles
   int fmode = 0;
   int fcount = 0;
   bit pop_ph = 1'b0;
   always @(posedge clk_vga) begin
      pop_ph <= ~pop_ph;
      if (fifo_flush) fcount <= 0;
      else fcount <= fcount + (fifo_write_enable ? 1 : 0)
                   - ((fmode == 1 && pop_ph && fcount > 0) ? 1 : 0);
   end
   assign fifo_half_full = (fmode == 1) && (fcount >= 4);
   assign fifo_full      = (fmode == 1) && (fcount >= 8);

   int rd_addr_q[$];
   int rd_cyc_q[$];
   int push_q[$];
   int push_cyc_q[$];
   int flush_cyc_q[$];
   int done_cyc_q[$];
   int ovf = 0;

   always @(negedge clk_vga) begin
      if (mem_rd_en) begin
         rd_addr_q.push_back(int'(mem_addr));
         rd_cyc_q.push_back(cyc);
      end
      if (fifo_write_enable) begin
         push_q.push_back(int'(fifo_write_data));
         push_cyc_q.push_back(cyc);
         if (fifo_full) ovf++;
      end
      if (fifo_flush) flush_cyc_q.push_back(cyc);
      if (frame_done) done_cyc_q.push_back(cyc);
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input longint act,
                        input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic pulse_sync(input logic sel, output int t);
      @(negedge clk_vga);
      frame_sync = 1'b1;
      buf_sel    = sel;
      t          = cyc;
      @(negedge clk_vga);
      frame_sync = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk_vga);
         if (done_cyc_q.size() > d0) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, ok, 1);
      repeat (4) @(negedge clk_vga);
   endtask

   task automatic wait_reads(input int r0, input int n);
      for (int i = 0; i < 500; i++) begin
         @(negedge clk_vga);
         if (rd_addr_q.size() - r0 >= n) return;
      end
      check("read_wait", 0, 1);
   endtask

   task automatic check_outs_reset(input string tag);
      check({tag, "_rd_en"}, mem_rd_en, 0);
      check({tag, "_addr"}, mem_addr, 0);
      check({tag, "_flush"}, fifo_flush, 0);
      check({tag, "_we"}, fifo_write_enable, 0);
      check({tag, "_wdata"}, fifo_write_data, 0);
      check({tag, "_done"}, frame_done, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_late"}, late_frames, 0);
   endtask

   typedef struct {
      logic sel;
      bit   toggle;
      int   mode;
      int   base;
   } vec_t;

   vec_t vecs[4];

   initial begin
      #4000000;
      $display("FAIL watchdog: no finish, cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t, t2, r0, p0, f0, d0, o0, bad, cnt, lp;
      vecs[0] = '{sel: 1'b0, toggle: 1'b0, mode: 0, base: B0};
      vecs[1] = '{sel: 1'b1, toggle: 1'b1, mode: 0, base: B1};
      vecs[2] = '{sel: 1'b0, toggle: 1'b0, mode: 1, base: B0};
      vecs[3] = '{sel: 1'b1, toggle: 1'b1, mode: 1, base: B1};

      #5 rst = 1'b1;
      repeat (3) @(negedge clk_vga);
      check_outs_reset("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk_vga);

      // full frames from the vector table
      foreach (vecs[i]) begin
         fmode = vecs[i].mode;
         r0 = rd_addr_q.size();
         p0 = push_q.size();
         f0 = flush_cyc_q.size();
         d0 = done_cyc_q.size();
         o0 = ovf;
         pulse_sync(vecs[i].sel, t);
         if (vecs[i].toggle) begin
            repeat (10) @(negedge clk_vga);
            buf_sel = ~vecs[i].sel;
         end
         wait_done(d0, $sformatf("v%0d_done_seen", i));
         check($sformatf("v%0d_flush_n", i),
               flush_cyc_q.size() - f0, 1);
         check($sformatf("v%0d_flush_t", i),
               (flush_cyc_q.size() > f0) ? flush_cyc_q[f0] - t : -1, 1);
         check($sformatf("v%0d_rd1_t", i),
               (rd_cyc_q.size() > r0) ? rd_cyc_q[r0] - t : -1, 3);
         check($sformatf("v%0d_rd_n", i), rd_addr_q.size() - r0, N);
         bad = 0;
         for (int k = 0; k < N && r0 + k < rd_addr_q.size(); k++)
            if (rd_addr_q[r0 + k] != vecs[i].base + k) bad++;
         check($sformatf("v%0d_addr_bad", i), bad, 0);
         check($sformatf("v%0d_push_n", i), push_q.size() - p0, N);
         check($sformatf("v%0d_push1_t", i),
               (push_cyc_q.size() > p0) ? push_cyc_q[p0] - t : -1, 5);
         bad = 0;
         for (int k = 0; k < N && p0 + k < push_q.size(); k++)
            if (push_q[p0 + k] != ((vecs[i].base + k) & 'hFFFF)) bad++;
         check($sformatf("v%0d_data_bad", i), bad, 0);
         lp = push_cyc_q[push_cyc_q.size() - 1];
         check($sformatf("v%0d_done_n", i), done_cyc_q.size() - d0, 1);
         check($sformatf("v%0d_done_t", i),
               done_cyc_q[done_cyc_q.size() - 1], lp);
         check($sformatf("v%0d_busy", i), busy, 0);
         check($sformatf("v%0d_ovf", i), ovf - o0, 0);
         check($sformatf("v%0d_late", i), late_frames, 0);
         if (vecs[i].mode == 0)
            check($sformatf("v%0d_last_t", i), lp - t, N + 4);
         else
            check($sformatf("v%0d_throttled", i), (lp - t) > N + 4, 1);
      end

      // abort mid-FILL at pixel 20
      fmode = 0;
      r0 = rd_addr_q.size();
      p0 = push_q.size();
      f0 = flush_cyc_q.size();
      d0 = done_cyc_q.size();
      pulse_sync(1'b0, t);
      wait_reads(r0, 20);
      pulse_sync(1'b1, t2);
      wait_done(d0, "ab_done_seen");
      check("ab_late", late_frames, 1);
      cnt = 0;
      for (int k = p0; k < push_q.size(); k++)
         if (push_cyc_q[k] > t2 && push_cyc_q[k] < t2 + 5) cnt++;
      check("ab_inflight", cnt, 0);
      bad = 0;
      for (int k = r0; k < rd_addr_q.size(); k++)
         if (rd_cyc_q[k] <= t2 - 2) bad++;
      cnt = 0;
      for (int k = p0; k < push_q.size(); k++)
         if (push_cyc_q[k] <= t2) cnt++;
      check("ab_old_push_n", cnt, bad);
      cnt = 0;
      for (int k = f0; k < flush_cyc_q.size(); k++)
         if (flush_cyc_q[k] == t2 + 1) cnt++;
      check("ab_reflush", cnt, 1);
      lp = -1;
      for (int k = r0; k < rd_addr_q.size(); k++)
         if (rd_cyc_q[k] > t2 && lp < 0) lp = k;
      check("ab_new_rd_t", (lp >= 0) ? rd_cyc_q[lp] - t2 : -1, 3);
      check("ab_new_addr", (lp >= 0) ? rd_addr_q[lp] : -1, B1);
      check("ab_new_rd_n", (lp >= 0) ? rd_addr_q.size() - lp : -1, N);
      lp = -1;
      for (int k = p0; k < push_q.size(); k++)
         if (push_cyc_q[k] > t2 && lp < 0) lp = k;
      check("ab_new_push_t", (lp >= 0) ? push_cyc_q[lp] - t2 : -1, 5);
      check("ab_new_data", (lp >= 0) ? push_q[lp] : -1, B1 & 'hFFFF);
      check("ab_done_n", done_cyc_q.size() - d0, 1);

      // frame_sync one cycle before the final push would register
      r0 = rd_addr_q.size();
      p0 = push_q.size();
      d0 = done_cyc_q.size();
      pulse_sync(1'b0, t);
      while (cyc < t + N + 2) @(negedge clk_vga);
      pulse_sync(1'b1, t2);
      wait_done(d0, "co_done_seen");
      check("co_late", late_frames, 2);
      cnt = 0;
      for (int k = p0; k < push_q.size(); k++)
         if (push_cyc_q[k] <= t2 + 1) cnt++;
      check("co_old_push_n", cnt, N - 1);
      cnt = 0;
      for (int k = d0; k < done_cyc_q.size(); k++)
         if (done_cyc_q[k] <= t2 + 1) cnt++;
      check("co_no_done", cnt, 0);
      check("co_done_n", done_cyc_q.size() - d0, 1);
      check("co_done_t", done_cyc_q[done_cyc_q.size() - 1] - t2, N + 4);
      lp = -1;
      for (int k = r0; k < rd_addr_q.size(); k++)
         if (rd_cyc_q[k] > t2 && lp < 0) lp = k;
      check("co_new_rd_t", (lp >= 0) ? rd_cyc_q[lp] - t2 : -1, 3);

      // late_frames saturation
      d0 = done_cyc_q.size();
      pulse_sync(1'b0, t);
      for (int k = 0; k < 252; k++) pulse_sync(1'b0, t2);
      check("sat_254", late_frames, 254);
      pulse_sync(1'b0, t2);
      check("sat_255", late_frames, 255);
      pulse_sync(1'b0, t2);
      check("sat_hold", late_frames, 255);
      wait_done(d0, "sat_done_seen");

      // asynchronous reset during FILL
      r0 = rd_addr_q.size();
      pulse_sync(1'b0, t);
      wait_reads(r0, 10);
      rst = 1'b1;
      #1;
      check_outs_reset("rst_fill");
      @(negedge clk_vga);
      rst = 1'b0;
      r0 = rd_addr_q.size();
      p0 = push_q.size();
      repeat (30) @(negedge clk_vga);
      check("rst_no_rd", rd_addr_q.size() - r0, 0);
      check("rst_no_push", push_q.size() - p0, 0);
      d0 = done_cyc_q.size();
      pulse_sync(1'b1, t);
      wait_done(d0, "rst_next_done");
      check("rst_next_rd_n", rd_addr_q.size() - r0, N);
      check("rst_next_addr", (rd_addr_q.size() > r0) ? rd_addr_q[r0] : -1,
            B1);
      check("rst_next_late", late_frames, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
